// File: rtl/pwm_accel_multilevel.sv
// Multilevel PWM accelerator: N cascaded H-bridge legs driven from level-shifted
// triangular carriers. Period, reference and dead-time are double-buffered and
// only take effect at the carrier valley (or when the block is enabled). Faults
// blank the gates combinationally and stay latched until software clears them.
module pwm_accel_multilevel #(
  parameter int N_BRIDGES  = 4,
  parameter int DATA_W     = 16,
  parameter int DT_W       = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_WIDTH-1:0]  wb_addr,
  input  logic [31:0]            wb_dat_i,
  output logic [31:0]            wb_dat_o,
  input  logic                   wb_we,
  input  logic [3:0]             wb_sel,
  input  logic                   wb_stb,
  output logic                   wb_ack,
  output logic [2*N_BRIDGES-1:0] pwm_out,
  output logic                   sync_out,
  input  logic                   fault
);

  // REF spans up to N_BRIDGES*PERIOD, so it needs three extra bits for N <= 8
  localparam int REF_W = DATA_W + 3;
  localparam int IDX_W = ADDR_WIDTH - 2;

  localparam logic [DATA_W-1:0] PERIOD_RST = DATA_W'(1000);
  localparam logic [DT_W-1:0]   DT_RST     = DT_W'(10);

  // Bus decode
  logic [IDX_W-1:0] idx;
  logic             acc;
  logic             wr;
  logic             wr_ctrl, wr_per, wr_ref, wr_dt, wr_stat, wr_shadow;
  logic [31:0]      rdata;

  // Registers and their next-state values
  logic              wb_ack_q, wb_ack_d;
  logic [31:0]       wb_dat_q, wb_dat_d;
  logic              enable_q, enable_d;
  logic [DATA_W-1:0] per_sh_q, per_sh_d, per_q, per_d;
  logic [REF_W-1:0]  ref_sh_q, ref_sh_d, ref_q, ref_d;
  logic [DT_W-1:0]   dt_sh_q, dt_sh_d, dt_q, dt_d;
  logic              pend_q, pend_d;
  logic              latch_q, latch_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic              dir_q, dir_d;
  logic              sync_q;

  logic [DATA_W-1:0]      p_eff;
  logic                   valley;
  logic                   en_rise;
  logic                   load_act;
  logic                   blank;
  logic [N_BRIDGES-1:0]   raw_q, raw_d;
  logic [2*N_BRIDGES-1:0] dt_out;

  // Byte selects and sub-word address bits carry no meaning for this block
  logic unused_bits;
  assign unused_bits = ^{wb_sel, wb_addr[1:0], wb_dat_i};

  assign idx       = wb_addr[ADDR_WIDTH-1:2];
  assign acc       = wb_stb & ~wb_ack_q;
  assign wr        = acc & wb_we;
  assign wr_ctrl   = wr & (idx == IDX_W'(0));
  assign wr_per    = wr & (idx == IDX_W'(1));
  assign wr_ref    = wr & (idx == IDX_W'(2));
  assign wr_dt     = wr & (idx == IDX_W'(3));
  assign wr_stat   = wr & (idx == IDX_W'(4));
  assign wr_shadow = wr_per | wr_ref | wr_dt;

  // A zero period would stall the carrier, so it runs as period 1
  assign p_eff    = (per_q == '0) ? DATA_W'(1) : per_q;
  assign valley   = enable_q & dir_q & (cnt_q <= DATA_W'(1));
  assign en_rise  = wr_ctrl & wb_dat_i[0] & ~enable_q;
  assign load_act = valley | en_rise;
  // Gates are forced off by a live fault, a latched fault or a disabled block
  assign blank    = fault | latch_q | ~enable_q;

  assign wb_ack   = wb_ack_q;
  assign wb_dat_o = wb_dat_q;
  assign sync_out = sync_q;
  assign pwm_out  = blank ? '0 : dt_out;

  // Register read multiplexer
  always_comb begin
    rdata = '0;
    case (idx)
      IDX_W'(0): rdata[0]              = enable_q;
      IDX_W'(1): rdata[DATA_W-1:0]     = per_sh_q;
      IDX_W'(2): rdata[REF_W-1:0]      = ref_sh_q;
      IDX_W'(3): rdata[DT_W-1:0]       = dt_sh_q;
      IDX_W'(4): rdata[2:0]            = {pend_q, dir_q, latch_q};
      IDX_W'(5): rdata[2*N_BRIDGES-1:0] = pwm_out;
      IDX_W'(6): rdata[DATA_W-1:0]     = cnt_q;
      default:   rdata = '0;
    endcase
  end

  // Control, shadow/active register and bus handshake next state
  always_comb begin
    wb_ack_d = acc;
    wb_dat_d = (acc & ~wb_we) ? rdata : wb_dat_q;
    enable_d = wr_ctrl ? wb_dat_i[0] : enable_q;
    per_sh_d = wr_per ? wb_dat_i[DATA_W-1:0] : per_sh_q;
    ref_sh_d = wr_ref ? wb_dat_i[REF_W-1:0]  : ref_sh_q;
    dt_sh_d  = wr_dt  ? wb_dat_i[DT_W-1:0]   : dt_sh_q;
    // Active set takes the shadow value held before any same-cycle write
    per_d    = load_act ? per_sh_q : per_q;
    ref_d    = load_act ? ref_sh_q : ref_q;
    dt_d     = load_act ? dt_sh_q  : dt_q;
    // A write coinciding with the transfer keeps the update pending
    if (wr_shadow) begin
      pend_d = 1'b1;
    end else if (load_act) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
    // Clearing is ignored while the fault input is still asserted
    latch_d  = fault | (latch_q & ~(wr_stat & wb_dat_i[0]));
  end

  // Triangular carrier: count up to P, back down to 0, held at 0 when disabled
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (!enable_q) begin
      cnt_d = '0;
      dir_d = 1'b0;
    end else if (!dir_q) begin
      if (cnt_q >= p_eff - DATA_W'(1)) begin
        cnt_d = p_eff;
        dir_d = 1'b1;
      end else begin
        cnt_d = cnt_q + DATA_W'(1);
      end
    end else begin
      if (cnt_q <= DATA_W'(1)) begin
        cnt_d = '0;
        dir_d = 1'b0;
      end else begin
        cnt_d = cnt_q - DATA_W'(1);
      end
    end
  end

  // State registers for bus, configuration, fault latch and carrier
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack_q <= 1'b0;
      wb_dat_q <= '0;
      enable_q <= 1'b0;
      per_sh_q <= PERIOD_RST;
      per_q    <= PERIOD_RST;
      ref_sh_q <= '0;
      ref_q    <= '0;
      dt_sh_q  <= DT_RST;
      dt_q     <= DT_RST;
      pend_q   <= 1'b0;
      latch_q  <= 1'b0;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      sync_q   <= 1'b0;
      raw_q    <= '0;
    end else begin
      wb_ack_q <= wb_ack_d;
      wb_dat_q <= wb_dat_d;
      enable_q <= enable_d;
      per_sh_q <= per_sh_d;
      per_q    <= per_d;
      ref_sh_q <= ref_sh_d;
      ref_q    <= ref_d;
      dt_sh_q  <= dt_sh_d;
      dt_q     <= dt_d;
      pend_q   <= pend_d;
      latch_q  <= latch_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      sync_q   <= valley;
      raw_q    <= raw_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_BRIDGES; gi++) begin : g_bridge
      logic [REF_W-1:0] thresh;
      logic             tgt_q, tgt_d;
      logic             hi_q, hi_d;
      logic             lo_q, lo_d;
      logic [DT_W-1:0]  dtc_q, dtc_d;

      // Carrier of bridge gi is shifted up by gi periods
      assign thresh    = REF_W'(gi) * REF_W'(p_eff) + REF_W'(cnt_q);
      assign raw_d[gi] = (ref_q > thresh);

      assign dt_out[2*gi]   = hi_q;
      assign dt_out[2*gi+1] = lo_q;

      // Dead-time: any change of the compare result blanks both sides for DT cycles
      always_comb begin
        tgt_d = tgt_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        dtc_d = dtc_q;
        if (blank) begin
          tgt_d = raw_q[gi];
          hi_d  = 1'b0;
          lo_d  = 1'b0;
          dtc_d = dt_q;
        end else if (raw_q[gi] != tgt_q) begin
          tgt_d = raw_q[gi];
          dtc_d = dt_q;
          if (dt_q == '0) begin
            hi_d = raw_q[gi];
            lo_d = ~raw_q[gi];
          end else begin
            hi_d = 1'b0;
            lo_d = 1'b0;
          end
        end else if (dtc_q > DT_W'(1)) begin
          dtc_d = dtc_q - DT_W'(1);
          hi_d  = 1'b0;
          lo_d  = 1'b0;
        end else begin
          dtc_d = '0;
          hi_d  = tgt_q;
          lo_d  = ~tgt_q;
        end
      end

      // Dead-time stage registers
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tgt_q <= 1'b0;
          hi_q  <= 1'b0;
          lo_q  <= 1'b0;
          dtc_q <= '0;
        end else begin
          tgt_q <= tgt_d;
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          dtc_q <= dtc_d;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pwm_accel_multilevel.sv
// Self-checking bench for pwm_accel_multilevel: directed scenarios followed by
// randomized register traffic and fault pulses, compared every cycle against a
// phase/time-window reference model of the carrier, compare and dead-time rules.
module tb_pwm_accel_multilevel;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int RW = DW + 3;
  localparam int TW = 8;
  localparam logic [2*N-1:0] EVEN = {N{2'b01}};

  logic           clk = 1'b0;
  logic           rst_n;
  logic [7:0]     wb_addr;
  logic [31:0]    wb_dat_i;
  logic [31:0]    wb_dat_o;
  logic           wb_we;
  logic [3:0]     wb_sel;
  logic           wb_stb;
  logic           wb_ack;
  logic [2*N-1:0] pwm_out;
  logic           sync_out;
  logic           fault;

  pwm_accel_multilevel #(
    .N_BRIDGES(N), .DATA_W(DW), .DT_W(TW), .ADDR_WIDTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wb_addr(wb_addr), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_we(wb_we), .wb_sel(wb_sel), .wb_stb(wb_stb),
    .wb_ack(wb_ack), .pwm_out(pwm_out), .sync_out(sync_out), .fault(fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t_now);
    end
  endtask

  // ---------------- reference model ----------------
  int          t_now;
  bit          m_en, m_pend, m_latch, m_sync, m_ack;
  int          m_per_sh, m_ref_sh, m_dt_sh, m_per, m_ref, m_dt, m_phase;
  logic [31:0] m_rdat;
  int          m_raw[N];
  int          m_raw_prev[N];
  int          m_blk[N];      // gates of bridge k are off through cycle m_blk[k]
  logic [1:0]  m_out[N];      // 01 = high side, 10 = low side, 00 = both off

  function automatic int p_eff();
    return (m_per == 0) ? 1 : m_per;
  endfunction

  // Carrier position as a phase 0..2P-1 folded into a triangle
  function automatic int m_cnt();
    int p;
    p = p_eff();
    return (m_phase <= p) ? m_phase : 2 * p - m_phase;
  endfunction

  function automatic bit m_dir();
    return m_phase >= p_eff();
  endfunction

  function automatic logic [2*N-1:0] m_pwm();
    logic [2*N-1:0] v;
    v = '0;
    if (!(fault || m_latch || !m_en))
      for (int k = 0; k < N; k++) v[2*k +: 2] = m_out[k];
    return v;
  endfunction

  function automatic logic [31:0] m_read(input int a);
    case (a)
      0: return {31'b0, m_en};
      1: return 32'(m_per_sh);
      2: return 32'(m_ref_sh);
      3: return 32'(m_dt_sh);
      4: return {29'b0, m_pend, m_dir(), m_latch};
      5: return 32'(m_pwm());
      6: return 32'(m_cnt());
      default: return 32'b0;
    endcase
  endfunction

  task automatic model_reset();
    t_now = 0;
    m_en = 0; m_pend = 0; m_latch = 0; m_sync = 0; m_ack = 0;
    m_per_sh = 1000; m_per = 1000; m_ref_sh = 0; m_ref = 0;
    m_dt_sh = 10; m_dt = 10; m_phase = 0; m_rdat = '0;
    for (int k = 0; k < N; k++) begin
      m_raw[k] = 0; m_raw_prev[k] = 0; m_blk[k] = 0; m_out[k] = 2'b00;
    end
  endtask

  // Advance the model by one clock using the inputs driven this cycle
  task automatic model_step();
    bit act, wr, valley, en_rise, w1c;
    int a, p, c;
    act = wb_stb && !m_ack;
    wr  = act && wb_we;
    a   = int'(wb_addr[7:2]);
    p   = p_eff();
    c   = m_cnt();
    if (act && !wb_we) m_rdat = m_read(a);
    for (int k = 0; k < N; k++) begin
      if (fault || m_latch || !m_en)
        m_blk[k] = t_now + ((m_dt > 0) ? m_dt : 1);
      else if (m_raw[k] != m_raw_prev[k])
        m_blk[k] = t_now + m_dt;
      m_out[k] = (t_now + 1 <= m_blk[k]) ? 2'b00 : ((m_raw[k] != 0) ? 2'b01 : 2'b10);
      m_raw_prev[k] = m_raw[k];
      m_raw[k] = (m_ref > k * p + c) ? 1 : 0;
    end
    valley  = m_en && (m_phase + 1 == 2 * p);
    en_rise = wr && (a == 0) && wb_dat_i[0] && !m_en;
    w1c     = wr && (a == 4) && wb_dat_i[0];
    m_sync  = valley;
    m_phase = m_en ? (valley ? 0 : m_phase + 1) : 0;
    if (valley || en_rise) begin
      m_per = m_per_sh; m_ref = m_ref_sh; m_dt = m_dt_sh; m_pend = 0;
    end
    m_latch = fault || (m_latch && !w1c);
    if (wr && a == 0) m_en = wb_dat_i[0];
    if (wr && (a == 1 || a == 2 || a == 3)) m_pend = 1;
    if (wr && a == 1) m_per_sh = int'(wb_dat_i[DW-1:0]);
    if (wr && a == 2) m_ref_sh = int'(wb_dat_i[RW-1:0]);
    if (wr && a == 3) m_dt_sh  = int'(wb_dat_i[TW-1:0]);
    m_ack = act;
    t_now++;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    #1;
    check_eq("pwm_out", 32'(pwm_out), 32'(m_pwm()));
    check_eq("shoot_through", 32'(pwm_out & (pwm_out >> 1) & EVEN), 32'd0);
    check_eq("sync_out", 32'(sync_out), 32'(m_sync));
    check_eq("wb_ack", 32'(wb_ack), 32'(m_ack));
    if (m_ack) check_eq("wb_dat_o", wb_dat_o, m_rdat);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wb_xfer(input bit we, input int addr, input int unsigned dat);
    wb_stb   = 1'b1;
    wb_we    = we;
    wb_addr  = 8'(addr);
    wb_dat_i = dat;
    tick();
    tick();
    $display("xfer %s addr=%02h data=%08h", we ? "wr" : "rd", addr, we ? dat : wb_dat_o);
    wb_stb   = 1'b0;
    wb_we    = 1'b0;
    wb_dat_i = '0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int sel, pe, guard, choice;
    rst_n = 1'b0; wb_addr = '0; wb_dat_i = '0; wb_we = 1'b0;
    wb_stb = 1'b0; wb_sel = 4'hF; fault = 1'b0;
    model_reset();
    repeat (3) begin
      @(posedge clk);
      #2;
      check_eq("rst_pwm", 32'(pwm_out), 32'd0);
      check_eq("rst_sync", 32'(sync_out), 32'd0);
      check_eq("rst_ack", 32'(wb_ack), 32'd0);
      check_eq("rst_dat", wb_dat_o, 32'd0);
    end
    rst_n = 1'b1;

    // Register defaults, including an unmapped word
    for (int a = 0; a < 8; a++) wb_xfer(1'b0, a * 4, 0);

    // Four levels, P=100, REF=250, no dead-time
    wb_xfer(1'b1, 'h04, 100);
    wb_xfer(1'b1, 'h08, 250);
    wb_xfer(1'b1, 'h0C, 0);
    wb_xfer(1'b1, 'h00, 1);
    idle(420);

    // Dead-time of 5 with the reference moved across the carrier
    wb_xfer(1'b1, 'h0C, 5);
    for (int i = 0; i < 6; i++) begin
      wb_xfer(1'b1, 'h08, $urandom_range(0, 400));
      idle($urandom_range(20, 90));
    end

    // Period change on the rising ramp stays pending until the valley
    guard = 0;
    while (!(m_en && !m_dir() && m_cnt() >= 30 && m_cnt() < 60) && guard < 400) begin
      tick();
      guard++;
    end
    wb_xfer(1'b1, 'h04, 50);
    wb_xfer(1'b0, 'h10, 0);
    wb_xfer(1'b0, 'h18, 0);
    idle(250);
    wb_xfer(1'b0, 'h10, 0);

    // Single-cycle fault, clear attempts with and without fault present
    fault = 1'b1;
    tick();
    fault = 1'b0;
    idle(8);
    wb_xfer(1'b0, 'h10, 0);
    fault = 1'b1;
    wb_xfer(1'b1, 'h10, 1);
    fault = 1'b0;
    idle(3);
    wb_xfer(1'b0, 'h10, 0);
    wb_xfer(1'b1, 'h10, 1);
    idle(20);

    // Disable mid-period, reprogram shadow, re-enable
    wb_xfer(1'b1, 'h00, 0);
    wb_xfer(1'b0, 'h18, 0);
    wb_xfer(1'b1, 'h04, 30);
    wb_xfer(1'b1, 'h00, 1);
    wb_xfer(1'b0, 'h18, 0);
    idle(80);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      pe  = (m_per_sh == 0) ? 1 : m_per_sh;
      case (sel)
        0: begin
          choice = $urandom_range(0, 3);
          wb_xfer(1'b1, 'h04, (choice == 0) ? 0 : (choice == 1) ? 1 :
                               (choice == 2) ? 2 : $urandom_range(3, 40));
        end
        1: begin
          choice = $urandom_range(0, 3);
          wb_xfer(1'b1, 'h08, (choice == 0) ? 0 : (choice == 1) ? N * pe :
                               (choice == 2) ? N * pe + 1 : $urandom_range(0, N * pe));
        end
        2: wb_xfer(1'b1, 'h0C, $urandom_range(0, 6));
        3: wb_xfer(1'b1, 'h00, ($urandom_range(0, 3) != 0) ? 1 : 0);
        4: begin
          fault = 1'b1;
          repeat ($urandom_range(1, 3)) tick();
          fault = 1'b0;
          idle(2);
        end
        5: begin
          fault = ($urandom_range(0, 3) == 0);
          wb_xfer(1'b1, 'h10, 1);
          fault = 1'b0;
        end
        6: wb_xfer(1'b0, $urandom_range(0, 7) * 4, 0);
        default: idle($urandom_range(5, 120));
      endcase
    end
    wb_xfer(1'b1, 'h10, 1);
    wb_xfer(1'b1, 'h00, 1);
    idle(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
